// File: rtl/bf2_pkg.sv
// Shared radix-2 stage definitions: frame counter width and lane-pairing index math.
// No logic, no latency; consumed by bf2_stage_pipe and its testbench.
package bf2_pkg;

    localparam int FRAME_CNT_W = 16;

    typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

    // Lane 'a' of pair i in group g; its partner 'b' sits exactly one stride above.
    function automatic int pair_lane_a(input int g, input int i, input int offset);
        return g * 2 * offset + i;
    endfunction

    function automatic int pair_lane_b(input int g, input int i, input int offset);
        return pair_lane_a(g, i, offset) + offset;
    endfunction

endpackage

// File: rtl/bf2_pair.sv
// One a/b butterfly (a+b, a-b) on a single rail with optional round-half-up halving.
// Purely combinational; no flow control.
module bf2_pair #(
    parameter int WIDTH = 9
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    scale,
    output logic signed [WIDTH:0]   sum,
    output logic signed [WIDTH:0]   dif
);

    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] b_ext;
    logic signed [WIDTH:0] sum_raw;
    logic signed [WIDTH:0] dif_raw;

    // (x+1)>>>1 rewritten as (x>>>1)+x[0]: identical result, never leaves WIDTH+1 bits.
    function automatic logic signed [WIDTH:0] halve_round(input logic signed [WIDTH:0] x);
        return (x >>> 1) + $signed({{WIDTH{1'b0}}, x[0]});
    endfunction

    assign a_ext   = {a[WIDTH-1], a};
    assign b_ext   = {b[WIDTH-1], b};
    assign sum_raw = a_ext + b_ext;
    assign dif_raw = a_ext - b_ext;

    assign sum = scale ? halve_round(sum_raw) : sum_raw;
    assign dif = scale ? halve_round(dif_raw) : dif_raw;

endmodule

// File: rtl/bf2_stage_pipe.sv
// Radix-2 butterfly stage over DEPTH I/Q lanes, stride OFFSET, one output register; 1-cycle latency.
// Full-throughput valid/ready: in_ready = ~out_valid | out_ready, forced low by clr. Option: BF2_SCALE_EN.
module bf2_stage_pipe
    import bf2_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 16,
    parameter int OFFSET = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic signed [WIDTH-1:0] din_R [DEPTH],
    input  logic signed [WIDTH-1:0] din_Q [DEPTH],
`ifdef BF2_SCALE_EN
    input  logic                    scale,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic signed [WIDTH:0]   dout_R [DEPTH],
    output logic signed [WIDTH:0]   dout_Q [DEPTH],
    output logic [FRAME_CNT_W-1:0]  frame_cnt
);

    localparam int GROUPS = DEPTH / (2 * OFFSET);

    if (OFFSET < 1 || (DEPTH % (2 * OFFSET)) != 0) begin : g_bad_cfg
        $error("bf2_stage_pipe: DEPTH must be a non-zero multiple of 2*OFFSET");
    end

    logic                  scale_sel;
    logic                  in_hs;
    logic                  out_hs;
    logic signed [WIDTH:0] res_r [DEPTH];
    logic signed [WIDTH:0] res_q [DEPTH];

`ifdef BF2_SCALE_EN
    assign scale_sel = scale;
`else
    assign scale_sel = 1'b0;
`endif

    assign in_ready = ~clr & (~out_valid | out_ready);
    assign in_hs    = in_valid & in_ready;
    assign out_hs   = out_valid & out_ready;

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        for (genvar i = 0; i < OFFSET; i++) begin : g_pair
            localparam int LA = pair_lane_a(g, i, OFFSET);
            localparam int LB = pair_lane_b(g, i, OFFSET);

            bf2_pair #(.WIDTH(WIDTH)) u_pair_r (
                .a     (din_R[LA]),
                .b     (din_R[LB]),
                .scale (scale_sel),
                .sum   (res_r[LA]),
                .dif   (res_r[LB])
            );

            bf2_pair #(.WIDTH(WIDTH)) u_pair_q (
                .a     (din_Q[LA]),
                .b     (din_Q[LB]),
                .scale (scale_sel),
                .sum   (res_q[LA]),
                .dif   (res_q[LB])
            );
        end
    end

    // Data and control share one register so a held bundle never tears under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_cnt <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dout_R[k] <= '0;
                dout_Q[k] <= '0;
            end
        end else if (clr) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (in_hs) begin
                out_valid <= 1'b1;
                out_last  <= in_last;
                dout_R    <= res_r;
                dout_Q    <= res_q;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
            if (out_hs && out_last) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bf2_stage_pipe.sv
// Bench for bf2_stage_pipe: directed vector table, backpressure/frame/clr/reset sequences,
// and a randomized valid/ready run scored against a queue-based reference model.
module tb_bf2_stage_pipe;

    localparam int W = 9;
    localparam int D = 16;
    localparam int O = 2;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic clr       = 1'b0;
    logic in_valid  = 1'b0;
    logic in_last   = 1'b0;
    logic out_ready = 1'b0;
`ifdef BF2_SCALE_EN
    logic scale     = 1'b0;
`endif
    logic in_ready;
    logic out_valid;
    logic out_last;
    logic signed [W-1:0] din_r [D];
    logic signed [W-1:0] din_q [D];
    logic signed [W:0]   dout_r [D];
    logic signed [W:0]   dout_q [D];
    logic [15:0]         frame_cnt;

    int errors = 0;
    int checks = 0;
    int sb[$];
    int mdl_fc = 0;

    typedef struct {
        int lane;
        bit rail_q;
        int va;
        int vb;
        bit sc;
        int ea;
        int eb;
    } vec_t;
    vec_t vt[$];

    always #5 clk = ~clk;

    bf2_stage_pipe #(.WIDTH(W), .DEPTH(D), .OFFSET(O)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .din_R     (din_r),
        .din_Q     (din_q),
`ifdef BF2_SCALE_EN
        .scale     (scale),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .dout_R    (dout_r),
        .dout_Q    (dout_q),
        .frame_cnt (frame_cnt)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit scale_on();
`ifdef BF2_SCALE_EN
        return scale;
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_scale(input bit s);
`ifdef BF2_SCALE_EN
        scale = s;
`else
        if (s) $display("scale request ignored in unscaled build");
`endif
    endtask

    // Reference: every lane in the lower half of its 2*O group is a sum, upper half a difference.
    function automatic int ref_lane(input int k, input bit rail_q, input bit sc);
        int base, a, b, x;
        base = k % (2 * O);
        if (base < O) begin
            a = rail_q ? int'(din_q[k])     : int'(din_r[k]);
            b = rail_q ? int'(din_q[k + O]) : int'(din_r[k + O]);
            x = a + b;
        end else begin
            a = rail_q ? int'(din_q[k - O]) : int'(din_r[k - O]);
            b = rail_q ? int'(din_q[k])     : int'(din_r[k]);
            x = a - b;
        end
        if (sc) x = (x + 1) >>> 1;
        return x;
    endfunction

    function automatic int out_lane(input int k, input bit rail_q);
        return rail_q ? int'(dout_q[k]) : int'(dout_r[k]);
    endfunction

    task automatic zero_din();
        for (int k = 0; k < D; k++) begin
            din_r[k] = '0;
            din_q[k] = '0;
        end
    endtask

    task automatic rand_din();
        for (int k = 0; k < D; k++) begin
            din_r[k] = W'($urandom);
            din_q[k] = W'($urandom);
        end
    endtask

    task automatic push_exp();
        for (int k = 0; k < D; k++) sb.push_back(ref_lane(k, 1'b0, scale_on()));
        for (int k = 0; k < D; k++) sb.push_back(ref_lane(k, 1'b1, scale_on()));
        sb.push_back(int'(in_last));
    endtask

    // Compare outputs against the oldest expected bundle; optionally retire it.
    task automatic cmp_head(input string tag, input bit consume);
        int bad_idx, bad_act, bad_exp;
        if (sb.size() < 2 * D + 1) return;
        bad_idx = -1;
        bad_act = 0;
        bad_exp = 0;
        for (int j = 0; j < 2 * D; j++) begin
            if (bad_idx < 0 && out_lane(j % D, j >= D) != sb[j]) begin
                bad_idx = j;
                bad_act = out_lane(j % D, j >= D);
                bad_exp = sb[j];
            end
        end
        if (bad_idx < 0 && int'(out_last) != sb[2 * D]) begin
            bad_idx = 2 * D;
            bad_act = int'(out_last);
            bad_exp = sb[2 * D];
        end
        checks++;
        if (bad_idx >= 0) begin
            errors++;
            $display("FAIL %s bundle word %0d: got %0d, expected %0d", tag, bad_idx, bad_act, bad_exp);
        end
        if (consume) begin
            if (sb[2 * D] != 0) mdl_fc = (mdl_fc + 1) % 65536;
            for (int j = 0; j <= 2 * D; j++) void'(sb.pop_front());
        end
    endtask

    task automatic sb_cycle(input string tag);
        #3;
        chk({tag, " out_valid"}, int'(out_valid), int'(sb.size() > 0));
        if (out_valid && out_ready) cmp_head(tag, 1'b1);
        if (in_valid && in_ready) push_exp();
        step();
    endtask

    initial begin
        vt.push_back('{lane: 0,  rail_q: 1'b0, va: 100,  vb: 50,   sc: 1'b0, ea: 150,  eb: 50});
        vt.push_back('{lane: 4,  rail_q: 1'b1, va: -256, vb: 255,  sc: 1'b0, ea: -1,   eb: -511});
        vt.push_back('{lane: 4,  rail_q: 1'b1, va: -256, vb: -256, sc: 1'b0, ea: -512, eb: 0});
        vt.push_back('{lane: 9,  rail_q: 1'b0, va: 255,  vb: 255,  sc: 1'b0, ea: 510,  eb: 0});
        vt.push_back('{lane: 13, rail_q: 1'b0, va: -1,   vb: 1,    sc: 1'b0, ea: 0,    eb: -2});
        vt.push_back('{lane: 1,  rail_q: 1'b1, va: 7,    vb: -8,   sc: 1'b0, ea: -1,   eb: 15});
`ifdef BF2_SCALE_EN
        vt.push_back('{lane: 0,  rail_q: 1'b0, va: 3,    vb: 0,    sc: 1'b1, ea: 2,    eb: 2});
        vt.push_back('{lane: 0,  rail_q: 1'b0, va: -3,   vb: 0,    sc: 1'b1, ea: -1,   eb: -1});
        vt.push_back('{lane: 9,  rail_q: 1'b0, va: 255,  vb: 255,  sc: 1'b1, ea: 255,  eb: 0});
        vt.push_back('{lane: 4,  rail_q: 1'b1, va: -256, vb: -256, sc: 1'b1, ea: -256, eb: 0});
`endif

        // Reset state
        zero_din();
        #12;
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst out_last", int'(out_last), 0);
        chk("rst frame_cnt", int'(frame_cnt), 0);
        chk("rst dout_r0", int'(dout_r[0]), 0);
        chk("rst dout_q15", int'(dout_q[15]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst in_ready", int'(in_ready), 1);

        // Directed vector table
        foreach (vt[n]) begin
            zero_din();
            if (vt[n].rail_q) begin
                din_q[vt[n].lane]     = W'(vt[n].va);
                din_q[vt[n].lane + O] = W'(vt[n].vb);
            end else begin
                din_r[vt[n].lane]     = W'(vt[n].va);
                din_r[vt[n].lane + O] = W'(vt[n].vb);
            end
            set_scale(vt[n].sc);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d out_valid", n), int'(out_valid), 1);
            chk($sformatf("vec%0d lane_a", n), out_lane(vt[n].lane, vt[n].rail_q), vt[n].ea);
            chk($sformatf("vec%0d lane_b", n), out_lane(vt[n].lane + O, vt[n].rail_q), vt[n].eb);
        end
        set_scale(1'b0);
        step();
        chk("vec drain out_valid", int'(out_valid), 0);

        // Backpressure: hold for 3 cycles, then stream back-to-back
        rand_din();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        sb_cycle("bp_load");
        for (int c = 0; c < 3; c++) begin
            rand_din();
            #1;
            chk("bp in_ready", int'(in_ready), 0);
            cmp_head("bp_hold", 1'b0);
            sb_cycle("bp_stall");
        end
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rand_din();
            #1;
            chk("b2b in_ready", int'(in_ready), 1);
            sb_cycle("b2b");
        end
        in_valid = 1'b0;
        sb_cycle("bp_drain");
        sb_cycle("bp_idle");

        // Randomized valid/ready/last/scale
        for (int c = 0; c < 1500; c++) begin
            rand_din();
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            in_last   = ($urandom % 5) == 0;
            set_scale(1'($urandom));
            sb_cycle("rnd");
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        set_scale(1'b0);
        sb_cycle("rnd_drain");
        sb_cycle("rnd_idle");
        chk("rnd frame_cnt", int'(frame_cnt), mdl_fc);

        // Frames: 4 x 8 bundles
        clr = 1'b1;
        step();
        clr = 1'b0;
        mdl_fc = 0;
        chk("frm start frame_cnt", int'(frame_cnt), 0);
        for (int n = 0; n < 32; n++) begin
            rand_din();
            in_valid = 1'b1;
            in_last  = (n % 8) == 7;
            sb_cycle("frm");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        sb_cycle("frm_drain");
        chk("frm frame_cnt", int'(frame_cnt), 4);

        // clr with a held bundle and a competing input
        rand_din();
        in_valid  = 1'b1;
        in_last   = 1'b1;
        out_ready = 1'b0;
        sb_cycle("clr_load");
        clr       = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("clr in_ready", int'(in_ready), 0);
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("clr out_valid", int'(out_valid), 0);
        chk("clr out_last", int'(out_last), 0);
        chk("clr frame_cnt", int'(frame_cnt), 0);
        sb.delete();
        mdl_fc = 0;

        // Reset mid-stream with a valid bundle held
        rand_din();
        in_valid = 1'b1;
        in_last  = 1'b1;
        step();
        zero_din();
        din_r[0] = W'(100);
        din_r[2] = W'(50);
        step();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        chk("mid frame_cnt", int'(frame_cnt), 1);
        chk("mid out_valid", int'(out_valid), 1);
        chk("mid dout_r0", int'(dout_r[0]), 150);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", int'(out_valid), 0);
        chk("arst dout_r0", int'(dout_r[0]), 0);
        chk("arst out_last", int'(out_last), 0);
        chk("arst frame_cnt", int'(frame_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post rst in_ready", int'(in_ready), 1);
        chk("post rst out_valid", int'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bf2_stage_pipe.md
BF2_STAGE_PIPE -- requirements
Module: bf2_stage_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 9: signed input sample width.
REQ-002 SHALL have parameter DEPTH, default 16: number of parallel complex lanes.
REQ-003 SHALL have parameter OFFSET, default 2: butterfly stride; DEPTH SHALL be a multiple of 2*OFFSET (elaboration error otherwise).
REQ-004 SHALL have port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port clr, input, 1: synchronous flush.
REQ-007 SHALL have port in_valid, input, 1: input bundle valid.
REQ-008 SHALL have port in_ready, output, 1: block can accept a bundle.
REQ-009 SHALL have port in_last, input, 1: last bundle of frame.
REQ-010 SHALL have port din_R / din_Q, input, signed [WIDTH-1:0] x DEPTH: I/Q lanes.
REQ-011 SHALL have port out_valid, output, 1: output bundle valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the bundle.
REQ-013 SHALL have port out_last, output, 1: in_last delayed with its bundle.
REQ-014 SHALL have port dout_R / dout_Q, output, signed [WIDTH:0] x DEPTH: butterfly results.
REQ-015 SHALL have port frame_cnt, output, 16: count of output handshakes with out_last=1, wrapping.

Function
REQ-016 SHALL pair lanes a=g*2*OFFSET+i and b=a+OFFSET, for g in 0..DEPTH/(2*OFFSET)-1 and i in 0..OFFSET-1.
REQ-017 SHALL compute dout[a]=din[a]+din[b] and dout[b]=din[a]-din[b], independently for R and Q.
REQ-018 SHALL sign-extend operands to WIDTH+1 before add/sub, so no overflow is possible.
REQ-019 SHALL form an input handshake when in_valid and in_ready are both high, and an output handshake when out_valid and out_ready are both high.
REQ-020 SHALL drive in_ready = ~out_valid | out_ready (one-entry pipeline register, full throughput).
REQ-021 SHALL register results, out_last and out_valid=1 on an input handshake; latency is 1 cycle.
REQ-022 SHALL clear out_valid on an output handshake without a simultaneous input handshake.
REQ-023 SHALL, on simultaneous input and output handshakes, load the new bundle and keep out_valid=1.
REQ-024 SHALL hold dout, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL increment frame_cnt on each output handshake with out_last=1, wrapping from 0xFFFF to 0.
REQ-026 SHALL, when clr=1, clear out_valid, out_last and frame_cnt, ignore in_valid that cycle, and drive in_ready=0.
REQ-027 SHALL give clr priority over all handshakes.

Reset
REQ-028 SHALL, while rst_n=0, clear out_valid, out_last, frame_cnt and all dout lanes to 0 immediately.
REQ-029 SHALL drive in_ready=1 after reset; a bundle in flight at reset is dropped.

Configuration
REQ-030 With BF2_SCALE_EN defined, SHALL add input port scale (1 bit, sampled with the input handshake); when scale=1, each result SHALL be (x+1)>>>1, computed at WIDTH+2 bits and truncated to WIDTH+1.
REQ-031 Without BF2_SCALE_EN, SHALL have no scale port and SHALL apply no scaling.

Structure
REQ-032 SHALL take FRAME_CNT_W=16 and the lane-pairing index function from shared package bf2_pkg.
REQ-033 SHALL instantiate combinational sub-module bf2_pair (one a/b add/sub with optional scale) per lane pair per rail.

Verification
REQ-034 Pairing: WIDTH=9, DEPTH=16, OFFSET=2, din_R[0]=100, din_R[2]=50, handshake -> next cycle dout_R[0]=150, dout_R[2]=50, out_valid=1.
REQ-035 Extremes: din_Q[4]=-256, din_Q[6]=255 -> dout_Q[4]=-1, dout_Q[6]=-511; din_Q[4]=din_Q[6]=-256 -> dout_Q[4]=-512.
REQ-036 Backpressure: out_ready=0 for 3 cycles after a handshake -> in_ready=0 and dout stable; out_ready=1 with in_valid=1 -> back-to-back throughput of 1 bundle/cycle.
REQ-037 Frames: 4 frames of 8 bundles, last on each 8th -> frame_cnt=4; clr pulse -> frame_cnt=0, out_valid=0.
REQ-038 Reset mid-stream: rst_n low while out_valid=1 -> out_valid=0 and dout=0 asynchronously, in_ready=1 after release.
REQ-039 BF2_SCALE_EN with scale=1: din_R[0]=3, din_R[2]=0 -> dout_R[0]=2, dout_R[2]=2; din_R[0]=-3, din_R[2]=0 -> dout_R[0]=-1.
